// File: rtl/csa_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : csa_accumulator
// Description : Multi-beat carry-save accumulator. Each accepted beat folds
//               three WIDTH-bit unsigned operands into a redundant sum/carry
//               pair through a 5:2 compressor built from three 3:2 levels. On
//               the frame's last beat, one ripple carry-propagate add resolves
//               the total, which is presented on an output handshake together
//               with the beat count and an overflow flag.
//
// Ports       : clk        rising-edge clock
//               rst        synchronous, active-high reset
//               in_valid   operand beat valid
//               in_ready   block can accept a beat (ACCUM state)
//               in_last    final beat of the frame (only meaningful with
//                          in_valid)
//               x, y, z    WIDTH-bit unsigned operands
//               out_valid  result valid (HOLD state)
//               out_ready  downstream accepts result
//               sum        frame total modulo 2^ACC_W
//               beats      beats accepted, saturating at MAX_BEATS
//               overflow   frame had more than MAX_BEATS beats
//
// Revision    : 1.0  initial release
// ============================================================================
module csa_accumulator #(
    parameter int WIDTH     = 4,
    parameter int MAX_BEATS = 16,
    parameter int ACC_W     = 10,
    localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic [CNT_W-1:0] beats,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_BEATS);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] r_s;          // redundant sum
    logic [ACC_W-1:0] r_c;          // redundant carry, already shifted left
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0] r_beats;
    logic             r_overflow;

    logic             w_accept;

    // ------------------------------------------------------------------
    // 5:2 compressor: three cascaded 3:2 levels. Every carry vector is
    // shifted left one place and truncated to ACC_W bits, so the pair
    // (S, C) always satisfies S + C == total (mod 2^ACC_W).
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] w_x;
    logic [ACC_W-1:0] w_y;
    logic [ACC_W-1:0] w_z;
    logic [ACC_W-1:0] w_s1;
    logic [ACC_W-1:0] w_c1;
    logic [ACC_W-1:0] w_s2;
    logic [ACC_W-1:0] w_c2;
    logic [ACC_W-1:0] w_s3;
    logic [ACC_W-1:0] w_c3;

    assign w_x = ACC_W'(x);
    assign w_y = ACC_W'(y);
    assign w_z = ACC_W'(z);

    // Level 1: the three new operands
    assign w_s1 = w_x ^ w_y ^ w_z;
    assign w_c1 = ((w_x & w_y) | (w_x & w_z) | (w_y & w_z)) << 1;

    // Level 2: fold in the running sum vector
    assign w_s2 = w_s1 ^ w_c1 ^ r_s;
    assign w_c2 = ((w_s1 & w_c1) | (w_s1 & r_s) | (w_c1 & r_s)) << 1;

    // Level 3: fold in the running carry vector
    assign w_s3 = w_s2 ^ w_c2 ^ r_c;
    assign w_c3 = ((w_s2 & w_c2) | (w_s2 & r_c) | (w_c2 & r_c)) << 1;

    // ------------------------------------------------------------------
    // Ripple carry-propagate adder resolving S + C. The carry out of the
    // top bit is never generated because the result is modulo 2^ACC_W.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] w_cpa_sum;
    logic [ACC_W-1:0] w_cpa_cin;

    assign w_cpa_cin[0] = 1'b0;

    for (genvar i = 0; i < ACC_W; i++) begin : g_cpa
        assign w_cpa_sum[i] = r_s[i] ^ r_c[i] ^ w_cpa_cin[i];
        if (i < ACC_W - 1) begin : g_carry
            assign w_cpa_cin[i+1] = (r_s[i] & r_c[i])
                                  | (r_s[i] & w_cpa_cin[i])
                                  | (r_c[i] & w_cpa_cin[i]);
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                // in_last only matters on a beat that is actually taken
                if (in_valid && in_last) begin
                    w_state_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_ACCUM;
                end
            end
            default: begin
                w_state_next = ST_ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s        <= '0;
            r_c        <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_sum      <= '0;
            r_beats    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_s <= w_s3;
                        r_c <= w_c3;
                        // A beat arriving when the count is already full
                        // means the frame is longer than guaranteed safe.
                        if (r_count == c_MAX_CNT) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                ST_RESOLVE: begin
                    r_sum      <= w_cpa_sum;
                    r_beats    <= r_count;
                    r_overflow <= r_ovf;
                end
                ST_HOLD: begin
                    // Result registers keep their values after the
                    // transfer; only the frame state is cleared.
                    if (out_ready) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: begin
                    r_s     <= '0;
                    r_c     <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end

    assign sum      = r_sum;
    assign beats    = r_beats;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
